// File: rtl/robot_hit_detect_pkg.sv
// Shared types and constants for the robot collision stage.
// The state enum, coordinate and compare widths, and the screen bounds.
package robot_hit_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      LAST,
      REPORT
   } state_e;

   localparam int COORD_W  = 10;
   localparam int CMP_W    = 11;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

endpackage

// File: rtl/robot_hit_detect_if.sv
// Hazard table read port: address out, registered entry data back one cycle later.
interface robot_hit_detect_if #(
   parameter int N_HAZ = 8
) ();

   logic [$clog2(N_HAZ)-1:0]          haz_idx;
   logic [robot_hit_pkg::COORD_W-1:0] haz_x;
   logic [robot_hit_pkg::COORD_W-1:0] haz_y;
   logic                              haz_valid;

   modport master (
      output haz_idx,
      input  haz_x,
      input  haz_y,
      input  haz_valid
   );

   modport slave (
      input  haz_idx,
      output haz_x,
      output haz_y,
      output haz_valid
   );

endinterface

// File: rtl/robot_hit_detect_box_overlap.sv
// Combinational axis-aligned box overlap test; touching edges do not count.
module box_overlap
   import robot_hit_pkg::*;
#(
   parameter int AW = 32,
   parameter int AH = 32,
   parameter int BW = 16,
   parameter int BH = 16
)(
   input  logic [COORD_W-1:0] ax_i,
   input  logic [COORD_W-1:0] ay_i,
   input  logic [COORD_W-1:0] bx_i,
   input  logic [COORD_W-1:0] by_i,
   output logic               overlap_o
);

   localparam logic [CMP_W-1:0] AW_C = CMP_W'(AW);
   localparam logic [CMP_W-1:0] AH_C = CMP_W'(AH);
   localparam logic [CMP_W-1:0] BW_C = CMP_W'(BW);
   localparam logic [CMP_W-1:0] BH_C = CMP_W'(BH);

   logic [CMP_W-1:0] axW, ayW, bxW, byW;

   // One extra bit keeps position + size from wrapping at the right/bottom edge.
   always_comb begin
      axW = CMP_W'(ax_i);
      ayW = CMP_W'(ay_i);
      bxW = CMP_W'(bx_i);
      byW = CMP_W'(by_i);
      overlap_o = (axW < bxW + BW_C) && (bxW < axW + AW_C) &&
                  (ayW < byW + BH_C) && (byW < ayW + AH_C);
   end

endmodule

// File: rtl/robot_hit_detect.sv
// Per-frame robot collision scan producing the movement block's Event pulses.
// Optional grace period after a robot death is enabled with `define ROBOT_HIT_GRACE_EN.
module robot_hit_detect
   import robot_hit_pkg::*;
#(
   parameter int N_HAZ = 8,
   parameter int R_W   = 32,
   parameter int R_H   = 32,
   parameter int H_W   = 16,
   parameter int H_H   = 16,
   parameter int D_W   = 64,
   parameter int D_H   = 64
`ifdef ROBOT_HIT_GRACE_EN
   ,parameter int GRACE_FRAMES = 4
`endif
)(
   input  logic                     clk_22,
   input  logic                     rst,
   input  logic                     frame_tick,
   input  logic [COORD_W-1:0]       r_x,
   input  logic [COORD_W-1:0]       r_y,
   input  logic                     r_valid,
   input  logic                     atk,
   input  logic [COORD_W-1:0]       d_x,
   input  logic [COORD_W-1:0]       d_y,
   input  logic                     d_valid,
   robot_hit_detect_if.master       haz,
   output logic [1:0]               Event,
   output logic [$clog2(N_HAZ)-1:0] hit_idx,
   output logic                     busy
);

   localparam int IDX_W = $clog2(N_HAZ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HAZ - 1);

   state_e             stateQ;
   logic [COORD_W-1:0] rxQ, ryQ, dxQ, dyQ;
   logic               rValidQ, atkQ, dValidQ;
   logic [IDX_W-1:0]   idxQ, firstIdxQ, hitIdxQ;
   logic               anyHitQ, busyQ;
   logic [1:0]         eventQ;

   logic               hazOverlap, dragonOverlap;
   logic               cmpEn, cmpHit;
   logic [IDX_W-1:0]   cmpIdx;
   logic               anyHitD;
   logic [IDX_W-1:0]   firstIdxD;
   logic               dieD, dieEff, dragonHitD;

   box_overlap #(.AW(R_W), .AH(R_H), .BW(H_W), .BH(H_H)) uHazOverlap (
      .ax_i      (rxQ),
      .ay_i      (ryQ),
      .bx_i      (haz.haz_x),
      .by_i      (haz.haz_y),
      .overlap_o (hazOverlap)
   );

   box_overlap #(.AW(R_W), .AH(R_H), .BW(D_W), .BH(D_H)) uDragonOverlap (
      .ax_i      (rxQ),
      .ay_i      (ryQ),
      .bx_i      (dxQ),
      .by_i      (dyQ),
      .overlap_o (dragonOverlap)
   );

   // Table data lags the address by one cycle, so the first SCAN cycle has nothing to compare.
   always_comb begin
      cmpEn      = ((stateQ == SCAN) && (idxQ != '0)) || (stateQ == LAST);
      cmpIdx     = (stateQ == LAST) ? idxQ : idxQ - IDX_W'(1);
      cmpHit     = cmpEn & haz.haz_valid & hazOverlap;
      anyHitD    = anyHitQ | cmpHit;
      firstIdxD  = (cmpHit && !anyHitQ) ? cmpIdx : firstIdxQ;
      dieD       = anyHitD & rValidQ;
      dragonHitD = atkQ & dValidQ & rValidQ & dragonOverlap;
   end

`ifdef ROBOT_HIT_GRACE_EN
   localparam int GW = $clog2(GRACE_FRAMES + 1);
   logic [GW-1:0] graceQ;
   assign dieEff = dieD & (graceQ == '0);
`else
   assign dieEff = dieD;
`endif

   always_ff @(posedge clk_22) begin
      if (rst) begin
         stateQ    <= IDLE;
         rxQ       <= '0;
         ryQ       <= '0;
         dxQ       <= '0;
         dyQ       <= '0;
         rValidQ   <= 1'b0;
         atkQ      <= 1'b0;
         dValidQ   <= 1'b0;
         idxQ      <= '0;
         firstIdxQ <= '0;
         hitIdxQ   <= '0;
         anyHitQ   <= 1'b0;
         busyQ     <= 1'b0;
         eventQ    <= 2'b00;
`ifdef ROBOT_HIT_GRACE_EN
         graceQ    <= '0;
`endif
      end else begin
         eventQ <= 2'b00;
         case (stateQ)
            IDLE: begin
               if (frame_tick) begin
                  rxQ       <= r_x;
                  ryQ       <= r_y;
                  rValidQ   <= r_valid;
                  atkQ      <= atk;
                  dxQ       <= d_x;
                  dyQ       <= d_y;
                  dValidQ   <= d_valid;
                  idxQ      <= '0;
                  anyHitQ   <= 1'b0;
                  firstIdxQ <= '0;
                  busyQ     <= 1'b1;
                  stateQ    <= SCAN;
               end
            end
            SCAN: begin
               anyHitQ   <= anyHitD;
               firstIdxQ <= firstIdxD;
               if (idxQ == LAST_IDX) begin
                  stateQ <= LAST;
               end else begin
                  idxQ <= idxQ + IDX_W'(1);
               end
            end
            LAST: begin
               anyHitQ   <= anyHitD;
               firstIdxQ <= firstIdxD;
               eventQ    <= {dragonHitD, dieEff};
               if (dieEff) begin
                  hitIdxQ <= firstIdxD;
               end
`ifdef ROBOT_HIT_GRACE_EN
               // Each report while the grace window is open spends one frame of it.
               if (graceQ != '0) begin
                  graceQ <= graceQ - GW'(1);
               end else if (dieD) begin
                  graceQ <= GW'(GRACE_FRAMES);
               end
`endif
               stateQ <= REPORT;
            end
            REPORT: begin
               busyQ  <= 1'b0;
               stateQ <= IDLE;
            end
            default: stateQ <= IDLE;
         endcase
      end
   end

   assign haz.haz_idx = idxQ;
   assign Event       = eventQ;
   assign hit_idx     = hitIdxQ;
   assign busy        = busyQ;

endmodule

// File: tb/tb_robot_hit_detect.sv
// Scoreboard bench for robot_hit_detect: a frame-level reference model queues expectations,
// a monitor pops one per completed scan. Define ROBOT_HIT_GRACE_EN to exercise the grace window.
module tb_robot_hit_detect;
   import robot_hit_pkg::*;

   localparam int N_HAZ   = 8;
   localparam int R_W     = 32;
   localparam int R_H     = 32;
   localparam int H_W     = 16;
   localparam int H_H     = 16;
   localparam int D_W     = 64;
   localparam int D_H     = 64;
   localparam int IDX_W   = $clog2(N_HAZ);
   localparam int LATENCY = N_HAZ + 2;
`ifdef ROBOT_HIT_GRACE_EN
   localparam int GRACE_FRAMES = 4;
`endif

   typedef struct {
      logic [1:0]       ev;
      logic [IDX_W-1:0] idx;
      int               tickCyc;
   } expT;

   logic             clk, rst, frameTick, rValid, atk, dValid;
   logic [9:0]       rX, rY, dX, dY;
   logic [1:0]       evt;
   logic [IDX_W-1:0] hitIdx;
   logic             busy;

   logic [9:0] hazX [N_HAZ];
   logic [9:0] hazY [N_HAZ];
   logic       hazV [N_HAZ];

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   expT expQ[$];
   bit  monitorOn = 0;
   int  mdlHitIdx = 0;
   int  mdlGrace = 0;

   bit               prevBusy = 0;
   bit               prevRst = 0;
   int               busyLen = 0;
   int               early = 0;
   logic [1:0]       lastEvt = '0;
   logic [IDX_W-1:0] lastIdx = '0;
   int               lastCyc = 0;

   robot_hit_detect_if #(.N_HAZ(N_HAZ)) hif ();

   robot_hit_detect #(
      .N_HAZ(N_HAZ), .R_W(R_W), .R_H(R_H), .H_W(H_W), .H_H(H_H), .D_W(D_W), .D_H(D_H)
`ifdef ROBOT_HIT_GRACE_EN
      ,.GRACE_FRAMES(GRACE_FRAMES)
`endif
   ) dut (
      .clk_22     (clk),
      .rst        (rst),
      .frame_tick (frameTick),
      .r_x        (rX),
      .r_y        (rY),
      .r_valid    (rValid),
      .atk        (atk),
      .d_x        (dX),
      .d_y        (dY),
      .d_valid    (dValid),
      .haz        (hif),
      .Event      (evt),
      .hit_idx    (hitIdx),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Registered-read hazard table
   always @(posedge clk) begin
      hif.haz_x     <= hazX[hif.haz_idx];
      hif.haz_y     <= hazY[hif.haz_idx];
      hif.haz_valid <= hazV[hif.haz_idx];
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit boxesOverlap(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
      return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
   endfunction

   function automatic logic [9:0] clampCoord(int v);
      if (v < 0) return 10'd0;
      if (v > 1023) return 10'd1023;
      return 10'(v);
   endfunction

   // Frame-level reference: whole-table search, then death/grace/hit-index bookkeeping.
   task automatic pushExpected();
      expT e;
      int  first = -1;
      bit  die, dhit;
      for (int k = N_HAZ - 1; k >= 0; k--) begin
         if (hazV[k] && boxesOverlap(int'(rX), int'(rY), R_W, R_H, int'(hazX[k]), int'(hazY[k]), H_W, H_H))
            first = k;
      end
      die  = (first >= 0) && (rValid == 1'b1);
      dhit = (atk == 1'b1) && (dValid == 1'b1) && (rValid == 1'b1) &&
             boxesOverlap(int'(rX), int'(rY), R_W, R_H, int'(dX), int'(dY), D_W, D_H);
`ifdef ROBOT_HIT_GRACE_EN
      if (mdlGrace > 0) begin
         die = 1'b0;
         mdlGrace--;
      end else if (die) begin
         mdlGrace = GRACE_FRAMES;
      end
`endif
      if (die) mdlHitIdx = first;
      e.ev      = {dhit, die};
      e.idx     = IDX_W'(mdlHitIdx);
      e.tickCyc = cyc;
      expQ.push_back(e);
   endtask

   task automatic clearTable();
      for (int k = 0; k < N_HAZ; k++) begin
         hazX[k] = '0;
         hazY[k] = '0;
         hazV[k] = 1'b0;
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      frameTick = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      mdlHitIdx = 0;
      mdlGrace = 0;
   endtask

   // One frame: tick, optional input scrambling mid-scan, optional extra ticks that must be ignored.
   task automatic applyStimulus(input bit scramble, input int extraTickDelay, input bit tickInReport);
      bit done = 0;
      for (int w = 0; w < 4 * LATENCY && busy === 1'b1; w++) @(posedge clk);
      @(posedge clk);
      #2;
      frameTick = 1'b1;
      pushExpected();
      for (int n = 1; n <= LATENCY + 8; n++) begin
         @(posedge clk);
         #2;
         frameTick = ((extraTickDelay != 0) && (n == extraTickDelay + 1)) ||
                     (tickInReport && (n == LATENCY));
         if (scramble) begin
            rX = 10'($urandom);
            rY = 10'($urandom);
            dX = 10'($urandom);
            dY = 10'($urandom);
            rValid = 1'($urandom);
            atk = 1'($urandom);
            dValid = 1'($urandom);
         end
         if (busy !== 1'b1) begin
            frameTick = 1'b0;
            done = 1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         frameTick = 1'b0;
         $display("[TB] FAIL scan_timeout: busy still %b after %0d cycles, required 0", busy, LATENCY + 8);
      end
   endtask

   // Monitor: one scoreboard entry per scan that ends normally; reset-aborted scans must stay silent.
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         if (monitorOn) begin
            if (busy === 1'b1) begin
               if (lastEvt != 2'b00) early++;
               busyLen++;
               lastEvt = evt;
               lastIdx = hitIdx;
               lastCyc = cyc;
            end else begin
               if (prevBusy) begin
                  if (prevRst) begin
                     checkOutput("abort_event_cycles", 32'(early + ((lastEvt != 2'b00) ? 1 : 0)), 32'd0);
                  end else if (expQ.size() == 0) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL unexpected_scan: scan ended with Event %b, required no scan", lastEvt);
                  end else begin
                     e = expQ.pop_front();
                     checkOutput("event", 32'(lastEvt), 32'(e.ev));
                     checkOutput("hit_idx", 32'(lastIdx), 32'(e.idx));
                     checkOutput("latency", 32'(lastCyc - e.tickCyc), 32'(LATENCY));
                     checkOutput("busy_len", 32'(busyLen), 32'(LATENCY));
                     checkOutput("early_event", 32'(early), 32'd0);
                  end
                  busyLen = 0;
                  early = 0;
                  lastEvt = '0;
               end else begin
                  checkOutput("idle_event", 32'(evt), 32'd0);
               end
            end
         end
         prevBusy = (busy === 1'b1);
         prevRst  = (rst === 1'b1);
      end
   end

   initial begin
      rst = 1'b1;
      frameTick = 1'b0;
      rX = '0; rY = '0; dX = '0; dY = '0;
      rValid = 1'b0; atk = 1'b0; dValid = 1'b0;
      clearTable();
      doReset();
      checkOutput("reset_event", 32'(evt), 32'd0);
      checkOutput("reset_hit_idx", 32'(hitIdx), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_haz_idx", 32'(hif.haz_idx), 32'd0);
      monitorOn = 1;

      $display("[TB] single hazard hit at entry 3");
      rX = 10'd100; rY = 10'd140; rValid = 1'b1;
      hazX[3] = 10'd120; hazY[3] = 10'd150; hazV[3] = 1'b1;
      applyStimulus(0, 0, 0);

      $display("[TB] touching edge then one pixel of overlap");
      clearTable();
      hazX[0] = 10'd132; hazY[0] = 10'd140; hazV[0] = 1'b1;
      applyStimulus(0, 0, 0);
      hazX[0] = 10'd131;
      applyStimulus(0, 0, 0);

      $display("[TB] two hits pick the lowest index; invalid overlapping entry ignored");
      clearTable();
      hazX[1] = 10'd100; hazY[1] = 10'd140; hazV[1] = 1'b0;
      hazX[2] = 10'd110; hazY[2] = 10'd150; hazV[2] = 1'b1;
      hazX[5] = 10'd90;  hazY[5] = 10'd130; hazV[5] = 1'b1;
      applyStimulus(0, 0, 0);
      rValid = 1'b0;
      applyStimulus(0, 0, 0);

      $display("[TB] dragon attack with and without atk");
      rValid = 1'b1;
      clearTable();
      dX = 10'd80; dY = 10'd100; dValid = 1'b1; atk = 1'b1;
      applyStimulus(0, 0, 0);
      atk = 1'b0;
      applyStimulus(0, 0, 0);

      $display("[TB] ticks while busy and during report are ignored; inputs scrambled mid-scan");
      atk = 1'b1;
      hazX[4] = 10'd105; hazY[4] = 10'd145; hazV[4] = 1'b1;
      applyStimulus(1, 3, 1);
      rX = 10'd100; rY = 10'd140; rValid = 1'b1;
      dX = 10'd80; dY = 10'd100; dValid = 1'b1; atk = 1'b1;
      applyStimulus(0, 0, 0);

      $display("[TB] reset in the middle of a scan");
      @(posedge clk);
      #2;
      frameTick = 1'b1;
      @(posedge clk);
      #2;
      frameTick = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_event", 32'(evt), 32'd0);
      checkOutput("rst_hit_idx", 32'(hitIdx), 32'd0);
      #1;
      rst = 1'b0;
      mdlHitIdx = 0;
      mdlGrace = 0;
      applyStimulus(0, 0, 0);

`ifdef ROBOT_HIT_GRACE_EN
      $display("[TB] grace window across six hitting frames");
      doReset();
      clearTable();
      hazX[6] = 10'd110; hazY[6] = 10'd150; hazV[6] = 1'b1;
      rX = 10'd100; rY = 10'd140; rValid = 1'b1;
      dX = 10'd80; dY = 10'd100; dValid = 1'b1; atk = 1'b1;
      repeat (6) applyStimulus(0, 0, 0);
`endif

      $display("[TB] randomized frames");
      for (int f = 0; f < 40; f++) begin
         rX = 10'($urandom_range(0, SCREEN_W - R_W));
         rY = 10'($urandom_range(0, SCREEN_H - R_H));
         rValid = ($urandom_range(0, 9) < 8);
         atk = 1'($urandom);
         dValid = ($urandom_range(0, 9) < 7);
         dX = clampCoord(int'(rX) + int'($urandom_range(0, 110)) - 70);
         dY = clampCoord(int'(rY) + int'($urandom_range(0, 110)) - 70);
         for (int k = 0; k < N_HAZ; k++) begin
            hazX[k] = clampCoord(int'(rX) + int'($urandom_range(0, 70)) - 45);
            hazY[k] = clampCoord(int'(rY) + int'($urandom_range(0, 70)) - 45);
            hazV[k] = ($urandom_range(0, 3) == 0);
         end
         applyStimulus(1'($urandom), 0, 0);
      end

      for (int i = 0; i < 50 && expQ.size() != 0; i++) @(posedge clk);
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL pending_expectations: %0d left, required 0", expQ.size());
      end
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
